serial_magnitude_comparator: RTL and testbench



---
 rtl/serial_magnitude_comparator.sv | 104 ++++++++++
 tb/tb_serial_magnitude_comparator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - MSB-first digit-serial magnitude comparator
// Unsigned or two's-complement compare with start/busy/done handshake and early exit.
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_bigger,
    output logic             b_bigger,
    output logic             equals
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
            $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, agt_q, bgt_q, eq_q;

    logic [WIDTH-1:0] msb_flip_d;
    logic [DIGIT-1:0] dig_a_d, dig_b_d;

    // Offset-binary mapping: flipping both sign bits turns a signed compare into an unsigned one.
    always_comb begin
        msb_flip_d            = '0;
        msb_flip_d[WIDTH-1]   = signed_mode;
        dig_a_d               = opa_q[WIDTH-1 -: DIGIT];
        dig_b_d               = opb_q[WIDTH-1 -: DIGIT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            agt_q   <= 1'b0;
            bgt_q   <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        opa_q   <= a ^ msb_flip_d;
                        opb_q   <= b ^ msb_flip_d;
                        cnt_q   <= '0;
                        agt_q   <= 1'b0;
                        bgt_q   <= 1'b0;
                        eq_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (dig_a_d != dig_b_d) begin
                        agt_q   <= (dig_a_d > dig_b_d);
                        bgt_q   <= (dig_a_d < dig_b_d);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == LAST) begin
                        eq_q    <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        opa_q <= opa_q << DIGIT;
                        opb_q <= opb_q << DIGIT;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign a_bigger = agt_q;
    assign b_bigger = bgt_q;
    assign equals   = eq_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - scoreboard bench for serial_magnitude_comparator
// Three instances (DIGIT 4, 1, 16) share clock and reset; expected results flow through per-instance queues.
module tb_serial_magnitude_comparator;
    localparam int W = 16;
    localparam int NI = 3;
    localparam int DIGS [NI] = '{4, 1, 16};

    typedef struct {
        logic [2:0] flags;
        int         due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_s [NI];
    logic         sm_s    [NI];
    logic [W-1:0] a_s     [NI];
    logic [W-1:0] b_s     [NI];
    logic         busy_s  [NI];
    logic         done_s  [NI];
    logic         agt_s   [NI];
    logic         bgt_s   [NI];
    logic         eq_s    [NI];

    exp_t exp_q [NI][$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            exp_t mon_e;
            serial_magnitude_comparator #(.WIDTH(W), .DIGIT(DIGS[g])) u_dut (
                .clk        (clk),
                .rst        (rst),
                .start      (start_s[g]),
                .signed_mode(sm_s[g]),
                .a          (a_s[g]),
                .b          (b_s[g]),
                .busy       (busy_s[g]),
                .done       (done_s[g]),
                .a_bigger   (agt_s[g]),
                .b_bigger   (bgt_s[g]),
                .equals     (eq_s[g])
            );

            always @(negedge clk) begin
                if (done_s[g] === 1'b1) begin
                    vectors++;
                    if (exp_q[g].size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_done inst=%0d cyc=%0d got flags=%b required no done",
                                 g, cyc, {agt_s[g], bgt_s[g], eq_s[g]});
                    end else begin
                        mon_e = exp_q[g].pop_front();
                        if ({agt_s[g], bgt_s[g], eq_s[g]} !== mon_e.flags || cyc != mon_e.due
                            || busy_s[g] !== 1'b0) begin
                            miscompares++;
                            $display("FAIL result inst=%0d got flags=%b cyc=%0d busy=%b required flags=%b cyc=%0d busy=0",
                                     g, {agt_s[g], bgt_s[g], eq_s[g]}, cyc, busy_s[g], mon_e.flags, mon_e.due);
                        end
                    end
                end else if (busy_s[g] === 1'b1 && {agt_s[g], bgt_s[g], eq_s[g]} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL flags_while_busy inst=%0d got flags=%b required 000",
                             g, {agt_s[g], bgt_s[g], eq_s[g]});
                end
            end
        end
    endgenerate

    // Reference: flags from plain signed/unsigned arithmetic; digits examined from leading zeros of a^b.
    function automatic void model(input int idx, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic sm, output logic [2:0] fl, output int k);
        logic [W-1:0] d;
        int lz;
        if (sm) begin
            if ($signed(av) > $signed(bv))      fl = 3'b100;
            else if ($signed(av) < $signed(bv)) fl = 3'b010;
            else                                fl = 3'b001;
        end else begin
            if (av > bv)      fl = 3'b100;
            else if (av < bv) fl = 3'b010;
            else              fl = 3'b001;
        end
        d = av ^ bv;
        if (d == '0) begin
            k = W / DIGS[idx];
        end else begin
            lz = 0;
            while (d[W-1] == 1'b0) begin
                d = d << 1;
                lz++;
            end
            k = lz / DIGS[idx] + 1;
        end
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    // Issues one compare at the current negedge; returns at the negedge of its done cycle.
    task automatic run(input int idx, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sm, input bit hold);
        exp_t e;
        int k;
        bit seen;
        model(idx, av, bv, sm, e.flags, k);
        e.due = cyc + k + 1;
        exp_q[idx].push_back(e);
        a_s[idx] = av;
        b_s[idx] = bv;
        sm_s[idx] = sm;
        start_s[idx] = 1'b1;
        if (hold) begin
            repeat (k) begin
                @(negedge clk);
                a_s[idx] = W'($urandom);
                b_s[idx] = W'($urandom);
                sm_s[idx] = 1'($urandom);
            end
        end
        @(negedge clk);
        start_s[idx] = 1'b0;
        a_s[idx] = W'($urandom);
        b_s[idx] = W'($urandom);
        sm_s[idx] = 1'($urandom);
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (done_s[idx] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout inst=%0d got no done required done by cyc=%0d", idx, e.due);
        end
    endtask

    task automatic rand_run(input int idx, input int n);
        logic [W-1:0] av, bv;
        for (int i = 0; i < n; i++) begin
            av = W'($urandom);
            case ($urandom_range(0, 3))
                0:       bv = av;
                1:       bv = av ^ (W'(1) << $urandom_range(0, W - 1));
                default: bv = W'($urandom);
            endcase
            run(idx, av, bv, 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            start_s[i] = 1'b0;
            sm_s[i] = 1'b0;
            a_s[i] = '0;
            b_s[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("reset_outputs inst%0d", i),
                  {3'b0, busy_s[i], done_s[i], agt_s[i], bgt_s[i], eq_s[i]}, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        run(0, 16'h1234, 16'h1234, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("flags_held", {5'b0, agt_s[0], bgt_s[0], eq_s[0]}, 8'b001);

        run(0, 16'h8000, 16'h7FFF, 1'b0, 1'b0);
        run(0, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
        run(0, 16'h12F4, 16'h12F5, 1'b0, 1'b0);
        run(0, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
        run(0, 16'h12F4, 16'h12F5, 1'b0, 1'b1);
        run(0, 16'h0003, 16'h0003, 1'b0, 1'b0);

        a_s[0] = 16'h1234;
        b_s[0] = 16'h1234;
        sm_s[0] = 1'b0;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q[0].delete();
        check("mid_scan_reset", {3'b0, busy_s[0], done_s[0], agt_s[0], bgt_s[0], eq_s[0]}, 8'h00);
        run(0, 16'h0001, 16'h0000, 1'b0, 1'b0);

        fork
            rand_run(0, 300);
            rand_run(1, 1000);
            rand_run(2, 1000);
        join
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("queue_drained inst%0d", i), 8'(exp_q[i].size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
